// File: rtl/rv32i_pkg.sv
// ------------------------------------------------------------------
// rv32i_pkg : shared types for the RV32I fetch path       (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ------------------------------------------------------------------
// fetch_buffer : 2-entry {pc, instr} FIFO feeding decode  (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module fetch_buffer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t entry_in,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   cnt;
  logic         pop_ok;
  logic         push_ok;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign count   = cnt;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Slot 0 is always the head; a pop shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= entry_in;
          else             slot1 <= entry_in;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= entry_in;
          end else begin
            slot0 <= slot1;
            slot1 <= entry_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = empty ? fetch_entry_t'{pc: RESET_PC, instr: NOP_INSTR} : slot0;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ------------------------------------------------------------------
// fetch_unit : RV32I fetch stage, PC + req/ack imem FSM    (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int          D_WIDTH  = 32,
  parameter int          A_WIDTH  = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [D_WIDTH-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [D_WIDTH-1:0] id_instr,
  output logic [A_WIDTH-1:0] id_pc,
  output logic [A_WIDTH-1:0] id_pc_plus4
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [A_WIDTH-1:0] pc;
  logic [A_WIDTH-1:0] pc_next;
  logic [A_WIDTH-1:0] pc_plus4;
  logic [A_WIDTH-1:0] target;
  logic [A_WIDTH-1:0] addr_next;
  logic               req_next;
  logic               push;
  logic               pop;
  logic               flush;
  logic               reissue;
  fetch_entry_t       entry_in;
  fetch_entry_t       head;
  logic [1:0]         count;
  logic               empty;
  logic               full;

  assign pc_plus4 = pc + A_WIDTH'(4);
  assign target   = redirect_pc & ~A_WIDTH'(3);
  assign pop      = id_valid && id_ready;
  assign entry_in = '{pc: pc, instr: imem_rdata};

  // The outstanding request occupies a slot, so a new one is only allowed
  // when the acked word plus the next request still fit after this cycle.
  assign reissue = (count == 2'd0) || ((count == 2'd1) && pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (redirect || !full) state_next = WAIT;
      WAIT: begin
        if (redirect)                   state_next = imem_ack ? WAIT : WAIT_DROP;
        else if (imem_ack && !reissue)  state_next = IDLE;
      end
      WAIT_DROP: if (imem_ack)          state_next = WAIT;
      default:                          state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next   = pc;
    req_next  = imem_req;
    addr_next = imem_addr;
    push      = 1'b0;
    flush     = redirect;
    if (redirect) begin
      pc_next = target;
      // A request still in flight must be held until its ack arrives.
      if (state == IDLE || imem_ack) begin
        req_next  = 1'b1;
        addr_next = target;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!full) begin
            req_next  = 1'b1;
            addr_next = pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            push    = 1'b1;
            pc_next = pc_plus4;
            if (reissue) addr_next = pc_plus4;
            else         req_next  = 1'b0;
          end
        end
        WAIT_DROP: begin
          if (imem_ack) addr_next = pc;
        end
        default: ;
      endcase
    end
  end

  fetch_buffer #(
    .RESET_PC (RESET_PC)
  ) u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .entry_in (entry_in),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  assign id_valid    = !empty;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_pc_plus4 = head.pc + A_WIDTH'(4);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ------------------------------------------------------------------
// tb_fetch_unit : self-checking bench for fetch_unit      (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RP  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          delivered = 0;
  logic [31:0] exp_pc = RP;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  fetch_unit #(
    .D_WIDTH  (32),
    .A_WIDTH  (32),
    .RESET_PC (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // Instruction memory contents: a fixed hash of the word address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // One cycle: observe at the falling edge, answer as memory, drive decode
  // inputs, and score what decode consumes against the expected PC stream.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic [31:0] p4;
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
        bad++;
        $display("FAIL handshake_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
      end
    end
    if (id_valid !== 1'b1) begin
      total++;
      if (id_instr !== NOP) begin
        bad++;
        $display("FAIL nop_when_empty: instr=%h, required %h", id_instr, NOP);
      end
    end
    if (imem_req === 1'b1) begin
      if (wait_cnt >= lat - 1) begin
        imem_ack   = 1'b1;
        imem_rdata = instr_of(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
    end
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    if (redir) begin
      exp_pc = tgt & 32'hFFFF_FFFC;
    end else if (id_valid === 1'b1 && rdy) begin
      total++;
      p4 = exp_pc + 32'd4;
      if (id_pc !== exp_pc || id_instr !== instr_of(exp_pc) || id_pc_plus4 !== p4) begin
        bad++;
        $display("FAIL deliver: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                 id_pc, id_instr, id_pc_plus4, exp_pc, instr_of(exp_pc), p4);
      end
      exp_pc = p4;
      delivered++;
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  endtask

  task automatic do_reset(input logic stray_ack);
    @(negedge clk);
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    id_ready    = 1'b0;
    wait_cnt    = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    exp_pc      = RP;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if (stray_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (id_valid !== 1'b1 && n < 20) begin
      tick(1'b1, 1'b0, 32'h0);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rp4;
    rp4 = RP + 32'd4;
    do_reset(1'b0);
    total++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4} !==
        {1'b0, RP, 1'b0, NOP, RP, rp4}) begin
      bad++;
      $display("FAIL reset_state: req=%b addr=%h v=%b instr=%h pc=%h pc4=%h, required 0 %h 0 %h %h %h",
               imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, RP, NOP, RP, rp4);
    end
  endtask

  task automatic test_stream();
    logic [31:0] p4;
    do_reset(1'b0);
    lat = 1;
    tick(1'b1, 1'b0, 32'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h v=%b, required 1 00000000 0", imem_req, imem_addr, id_valid);
    end
    tick(1'b1, 1'b0, 32'h0);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      bad++;
      $display("FAIL first_valid: v=%b pc=%h, required 1 00000000", id_valid, id_pc);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      p4 = id_pc + 32'd4;
      total++;
      if (id_valid !== 1'b1 || id_pc_plus4 !== p4 || imem_addr !== p4) begin
        bad++;
        $display("FAIL steady_stream: v=%b pc4=%h addr=%h, required 1 %h %h", id_valid, id_pc_plus4, imem_addr, p4, p4);
      end
    end
  endtask

  task automatic test_stall();
    int d0;
    int n = 0;
    do_reset(1'b0);
    lat = 1;
    repeat (10) tick(1'b0, 1'b0, 32'h0);
    total++;
    if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
      bad++;
      $display("FAIL stall_hold: req=%b v=%b pc=%h, required 0 1 00000000", imem_req, id_valid, id_pc);
    end
    d0 = delivered;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h4) begin
      bad++;
      $display("FAIL stall_second: v=%b pc=%h, required 1 00000004", id_valid, id_pc);
    end
    while (delivered < d0 + 3 && n < 20) begin
      tick(1'b1, 1'b0, 32'h0);
      n++;
    end
    total++;
    if (delivered < d0 + 3) begin
      bad++;
      $display("FAIL stall_drain: delivered=%0d, required %0d", delivered - d0, 3);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b0);
    lat = 3;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h100);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_wait_addr: req=%b addr=%h v=%b, required 1 00000100 0", imem_req, imem_addr, id_valid);
    end
    wait_valid();
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      bad++;
      $display("FAIL redir_wait_first: v=%b pc=%h, required 1 00000100", id_valid, id_pc);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset(1'b0);
    lat = 1;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h203);
    total++;
    if (imem_ack !== 1'b1 || id_valid !== 1'b1) begin
      bad++;
      $display("FAIL redir_ack_setup: ack=%b v=%b, required 1 1", imem_ack, id_valid);
    end
    tick(1'b1, 1'b0, 32'h0);
    total++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++;
      $display("FAIL redir_ack_flush: v=%b req=%b addr=%h, required 0 1 00000200", id_valid, imem_req, imem_addr);
    end
    wait_valid();
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      bad++;
      $display("FAIL redir_ack_first: v=%b pc=%h, required 1 00000200", id_valid, id_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    lat = 1;
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_valid();
    total++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap: v=%b pc=%h pc4=%h addr=%h, required 1 fffffffc 00000000 00000000",
               id_valid, id_pc, id_pc_plus4, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rp4;
    rp4 = RP + 32'd4;
    do_reset(1'b0);
    lat = 3;
    repeat (5) tick(1'b0, 1'b0, 32'h0);
    total++;
    if (id_valid !== 1'b1 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_setup: v=%b req=%b, required 1 1", id_valid, imem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4} !==
        {1'b0, RP, 1'b0, NOP, RP, rp4}) begin
      bad++;
      $display("FAIL reset_async: req=%b addr=%h v=%b instr=%h pc=%h pc4=%h, required 0 %h 0 %h %h %h",
               imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, RP, NOP, RP, rp4);
    end
    do_reset(1'b1);
    lat = 1;
    wait_valid();
    total++;
    if (id_valid !== 1'b1 || id_pc !== RP || id_instr !== instr_of(RP)) begin
      bad++;
      $display("FAIL reset_refetch: v=%b pc=%h instr=%h, required 1 %h %h", id_valid, id_pc, id_instr, RP, instr_of(RP));
    end
  endtask

  task automatic test_random();
    int d0;
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      lat = $urandom_range(1, 3);
      d0 = delivered;
      for (int i = 0; i < 150; i++) begin
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      end
      total++;
      if (delivered - d0 < 10) begin
        bad++;
        $display("FAIL random_progress: delivered=%0d, required >= 10", delivered - d0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
